fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
// - Instruction prefetch buffer between instruction memory and the decode stage of the pipelined core.
// - Owns the fetch PC, reads the instruction memory once per cycle and queues {instruction, PC+1} pairs.
// - Hands queued entries to decode under a stall handshake and flushes on branch/jump redirects.
// PARAMETERS
// - addWidth   6   instruction address width; fetch PC wraps mod 2**addWidth
// - dataWidth  32  instruction width
// - DEPTH      4   queue entries; power of two, >= 2
// PORTS
// - clk           in   1          single clock; all state on rising edge
// - reset         in   1          asynchronous, active-high; clears all state immediately
// - imem_addr     out  addWidth   fetch PC to instruction memory (= fetch_pc register)
// - imem_data     in   dataWidth  instruction at imem_addr, combinational read, same cycle
// - redirect      in   1          branch/jump taken; flush queue, restart fetch
// - redirect_pc   in   addWidth   new fetch PC when redirect=1
// - stall_d       in   1          decode cannot accept this cycle
// - instr_d       out  dataWidth  head instruction to decode; NOP (0) when empty
// - pc_plus1_d    out  addWidth   PC+1 of head instruction; 0 when empty
// - valid_d       out  1          head entry valid
// - count         out  clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
// - Reset: fetch_pc=0, rd_ptr=wr_ptr=0, count=0, storage cleared; so valid_d=0, instr_d=0, pc_plus1_d=0, imem_addr=0.
// - Reset mid-operation: all in-flight entries discarded at once; fetch restarts at PC 0 on the first edge after release.
// - push = !redirect && (count < DEPTH); on push: mem[wr_ptr] <= {imem_data, fetch_pc+1}, wr_ptr++, fetch_pc <= fetch_pc+1.
// - pop = !redirect && valid_d && !stall_d; on pop: rd_ptr++.
// - count_next = count + push - pop; push and pop in the same cycle leave count unchanged.
// - Full (count==DEPTH): no push even if popping this cycle (no comb path stall_d->imem); fetch_pc holds.
//   Steady state with stall_d=0 still sustains one instruction per cycle at count DEPTH-1.
// - Empty (count==0): valid_d=0, instr_d=0, pc_plus1_d=0; pop suppressed regardless of stall_d.
// - Outputs are a mux of registered storage at rd_ptr; no combinational path from any input to instr_d/valid_d/count.
// - Latency: instruction at PC p fetched in cycle t is on instr_d with valid_d=1 in cycle t+1 if queue was empty.
// - Redirect (highest priority): next edge count=0, rd_ptr=wr_ptr=0, fetch_pc<=redirect_pc; no push/pop that cycle,
//   imem_data ignored. First redirected instruction valid two cycles after redirect asserted.
// - Redirect while full or while stall_d=1: same flush; stall_d has no effect on redirect.
// - Pointers are log2(DEPTH) bits, wrap naturally; fetch_pc+1 wraps from 2**addWidth-1 to 0.
// - pc_plus1_d width addWidth; arithmetic truncates, no carry out.
// STRUCTURE
// - Shared package/include: NOP_INSTR = 32'h0, default addWidth/dataWidth, clog2 helper function.
// - One sub-module: fetch_queue_ram (DEPTH x (dataWidth+addWidth) register array, sync write, async read,
//   asynchronous clear on reset). Pointer/count/fetch_pc control stays in fetch_queue.
// TESTING
// - Reset release, imem[i]=32'h100+i, stall_d=0 -> cycle 1: instr_d=32'h100, pc_plus1_d=1; then 101,102,... one per cycle.
// - stall_d=1 for 8 cycles from reset -> count rises 1..4, holds 4, imem_addr holds 4; release -> 100..103 then 104 with no gap/dup.
// - At count=3 steady stream, pulse redirect=1, redirect_pc=6'd40 -> next cycle valid_d=0, count=0, imem_addr=40;
//   following cycle instr_d=imem[40], pc_plus1_d=41.
// - Redirect with stall_d=1 and count=4 -> flush wins, count=0, no entry popped, fetch resumes at redirect_pc.
// - redirect_pc=6'd62, stream 3 instrs -> pc_plus1_d sequence 63, 0, 1 (wrap); ptr wrap over >DEPTH pushes intact.
// - Assert reset asynchronously mid-stream (between edges) -> valid_d, count, imem_addr go 0 immediately; restart at PC 0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the instruction prefetch queue.
package fetch_queue_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Ceiling log2, for sizing pointers and the occupancy counter.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Queue storage: register array with synchronous write, asynchronous read
// and asynchronous clear.
module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we_i,
    input  logic [clog2(DEPTH)-1:0]   waddr_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic [clog2(DEPTH)-1:0]   raddr_i,
    output logic [WIDTH-1:0]          rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Entry storage; reset wipes every slot so a stale entry can never resurface.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: owns the fetch PC, queues {instr, PC+1} pairs
// and hands them to decode; a redirect flushes everything and restarts fetch.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int addWidth  = ADDR_W_DEF,
    parameter int dataWidth = DATA_W_DEF,
    parameter int DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [addWidth-1:0]           imem_addr,
    input  logic [dataWidth-1:0]          imem_data,
    input  logic                          redirect,
    input  logic [addWidth-1:0]           redirect_pc,
    input  logic                          stall_d,
    output logic [dataWidth-1:0]          instr_d,
    output logic [addWidth-1:0]           pc_plus1_d,
    output logic                          valid_d,
    output logic [clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);
    localparam int ENT_W = dataWidth + addWidth;

    logic [addWidth-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                push_s, pop_s, valid_s;
    logic [addWidth-1:0] pc_plus1_s;
    logic [ENT_W-1:0]    rdata_s;

    assign valid_s    = (count_q != {CNT_W{1'b0}});
    assign pc_plus1_s = fetch_pc_q + addWidth'(1'b1);

    // Next-state control; redirect overrides both push and pop.
    always_comb begin
        push_s     = 1'b0;
        pop_s      = 1'b0;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = {PTR_W{1'b0}};
            wr_ptr_d   = {PTR_W{1'b0}};
            count_d    = {CNT_W{1'b0}};
        end else begin
            // Push depends only on registered count, never on stall_d.
            push_s   = (count_q < CNT_W'(DEPTH));
            pop_s    = valid_s && !stall_d;
            if (push_s) begin
                fetch_pc_d = pc_plus1_s;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                fetch_pc_d = fetch_pc_q;
                wr_ptr_d   = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= {addWidth{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i ({imem_data, pc_plus1_s}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

    // Head presentation; an empty queue shows a NOP so decode sees nothing stale.
    always_comb begin
        instr_d    = dataWidth'(NOP_INSTR);
        pc_plus1_d = {addWidth{1'b0}};
        if (valid_s) begin
            instr_d    = rdata_s[ENT_W-1:addWidth];
            pc_plus1_d = rdata_s[addWidth-1:0];
        end else begin
            instr_d    = dataWidth'(NOP_INSTR);
            pc_plus1_d = {addWidth{1'b0}};
        end
    end

    assign valid_d   = valid_s;
    assign count     = count_q;
    assign imem_addr = fetch_pc_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; instruction memory returns 32'h100 + address.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [5:0]  redirect_pc;
    logic        stall_d;
    logic [31:0] instr_d;
    logic [5:0]  pc_plus1_d;
    logic        valid_d;
    logic [2:0]  count;

    int total;
    int bad;

    fetch_queue #(
        .addWidth  (6),
        .dataWidth (32),
        .DEPTH     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall_d     (stall_d),
        .instr_d     (instr_d),
        .pc_plus1_d  (pc_plus1_d),
        .valid_d     (valid_d),
        .count       (count)
    );

    assign imem_data = 32'h0000_0100 + {26'd0, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 6'd0;
        stall_d     = 1'b0;
        #12;
        chk("rst_valid", 64'(valid_d), 64'd0);
        chk("rst_instr", 64'(instr_d), 64'd0);
        chk("rst_pc1",   64'(pc_plus1_d), 64'd0);
        chk("rst_addr",  64'(imem_addr), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        reset = 1'b0;

        // Free-running stream: one instruction per cycle.
        tick();
        chk("first_valid", 64'(valid_d), 64'd1);
        chk("first_instr", 64'(instr_d), 64'h100);
        chk("first_pc1",   64'(pc_plus1_d), 64'd1);
        chk("first_count", 64'(count), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("stream_instr", 64'(instr_d), 64'h100 + 64'(k));
            chk("stream_pc1",   64'(pc_plus1_d), 64'(k + 1));
        end

        // Asynchronous reset between edges.
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(valid_d), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_addr",  64'(imem_addr), 64'd0);
        chk("arst_instr", 64'(instr_d), 64'd0);
        stall_d = 1'b1;
        #1;
        reset = 1'b0;

        // Stalled fill from PC 0 up to full.
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("fill_count", 64'(count), 64'((k < 4) ? k : 4));
            chk("fill_addr",  64'(imem_addr), 64'((k < 4) ? k : 4));
            chk("fill_instr", 64'(instr_d), 64'h100);
        end
        stall_d = 1'b0;
        #1;
        chk("drain_head", 64'(instr_d), 64'h100);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("drain_instr", 64'(instr_d), 64'h100 + 64'(k));
            chk("drain_count", 64'(count), 64'd3);
            chk("drain_addr",  64'(imem_addr), 64'(3 + k));
        end

        // Redirect from a steady stream at count 3.
        redirect    = 1'b1;
        redirect_pc = 6'd40;
        tick();
        redirect = 1'b0;
        chk("redir_valid", 64'(valid_d), 64'd0);
        chk("redir_count", 64'(count), 64'd0);
        chk("redir_addr",  64'(imem_addr), 64'd40);
        chk("redir_instr", 64'(instr_d), 64'd0);
        chk("redir_pc1",   64'(pc_plus1_d), 64'd0);
        tick();
        chk("redir_first_instr", 64'(instr_d), 64'h128);
        chk("redir_first_pc1",   64'(pc_plus1_d), 64'd41);
        chk("redir_first_count", 64'(count), 64'd1);

        // Redirect while full and stalled.
        stall_d = 1'b1;
        tick();
        tick();
        tick();
        chk("full_count", 64'(count), 64'd4);
        chk("full_instr", 64'(instr_d), 64'h128);
        chk("full_addr",  64'(imem_addr), 64'd44);
        redirect    = 1'b1;
        redirect_pc = 6'd10;
        tick();
        redirect = 1'b0;
        stall_d  = 1'b0;
        chk("sredir_count", 64'(count), 64'd0);
        chk("sredir_valid", 64'(valid_d), 64'd0);
        chk("sredir_addr",  64'(imem_addr), 64'd10);
        tick();
        chk("sredir_instr", 64'(instr_d), 64'h10A);
        chk("sredir_pc1",   64'(pc_plus1_d), 64'd11);
        chk("sredir_cnt1",  64'(count), 64'd1);

        // PC wrap at the top of the address space, pointers wrap too.
        redirect    = 1'b1;
        redirect_pc = 6'd62;
        tick();
        redirect = 1'b0;
        tick();
        chk("wrap0_instr", 64'(instr_d), 64'h13E);
        chk("wrap0_pc1",   64'(pc_plus1_d), 64'd63);
        tick();
        chk("wrap1_instr", 64'(instr_d), 64'h13F);
        chk("wrap1_pc1",   64'(pc_plus1_d), 64'd0);
        tick();
        chk("wrap2_instr", 64'(instr_d), 64'h100);
        chk("wrap2_pc1",   64'(pc_plus1_d), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ptrwrap_instr", 64'(instr_d), 64'h101 + 64'(k));
            chk("ptrwrap_pc1",   64'(pc_plus1_d), 64'(2 + k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
